pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter HOLD_CYCLES, default 25000000; number of clk cycles salida is held high per event (minimum 1).
REQ-002 Parameter GAP_CYCLES, default 10000000; number of low clk cycles forced between two consecutive output pulses (minimum 1).
REQ-003 Parameter QUEUE_MAX, default 7; saturation value of the pending-event counter (minimum 1).
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 evento  input  1  single-cycle event pulse, synchronous to clk (e.g. the debounced button-release pulse).
REQ-007 salida  output  1  stretched pulse driving a physical indicator (LED/buzzer); registered.
REQ-008 ocupado  output  1  high whenever the state is not IDLE or the pending count is nonzero; registered.
REQ-009 perdido  output  1  one-cycle pulse flagging an event that was discarded; registered.

Function
REQ-010 The FSM SHALL have three states: IDLE, ACTIVE, GAP; one down-counter of width clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) SHALL serve both timed states.
REQ-011 IDLE with evento=1 SHALL move to ACTIVE on that edge, so salida is high from the next cycle, i.e. latency exactly 1 cycle.
REQ-012 ACTIVE SHALL keep salida=1 for exactly HOLD_CYCLES cycles, then enter GAP.
REQ-013 GAP SHALL keep salida=0 for exactly GAP_CYCLES cycles, then enter ACTIVE if the pending count is nonzero (decrementing it on that edge), else IDLE.
REQ-014 IDLE with a nonzero pending count SHALL NOT occur; leaving GAP always consumes a pending event first.
REQ-015 An evento arriving while in ACTIVE or GAP SHALL be handled per REQ-021/REQ-022; it SHALL never extend or restart the current pulse.
REQ-016 evento on the same edge that GAP expires with pending count zero SHALL start a new ACTIVE immediately, with no IDLE cycle.
REQ-017 evento on the same edge that GAP expires with nonzero pending count SHALL be counted (increment and decrement in the same cycle leave the count unchanged).
REQ-018 evento held high for N cycles SHALL be treated as N events.

Reset
REQ-019 While reset=0: state IDLE, counter 0, pending count 0, salida=0, ocupado=0, perdido=0, asynchronously.
REQ-020 Reset asserted mid-pulse SHALL drop salida within the same cycle and discard all pending events; the first rising clk edge after release SHALL be treated as normal IDLE operation.

Configuration
REQ-021 With PULSE_STRETCHER_QUEUE_EN defined, an evento during ACTIVE/GAP SHALL increment the pending count (saturating at QUEUE_MAX); an evento arriving while the count equals QUEUE_MAX SHALL be discarded and pulse perdido for one cycle.
REQ-022 Without PULSE_STRETCHER_QUEUE_EN, no pending counter SHALL exist; every evento during ACTIVE/GAP SHALL be discarded and pulse perdido for one cycle, and GAP always exits to IDLE (or ACTIVE per REQ-016).

Structure
REQ-023 State encoding (IDLE=2'b00, ACTIVE=2'b01, GAP=2'b10) and default parameter values SHALL live in a shared package, pulse_stretcher_pkg, reusable by other indicator blocks.
REQ-024 The block SHALL be flat; the pending counter is not a separate sub-module.

Verification (HOLD_CYCLES=4, GAP_CYCLES=2, QUEUE_MAX=2)
REQ-025 Single evento at cycle 10 -> salida high in cycles 11-14, low from 15, ocupado low from cycle 17, perdido never high.
REQ-026 QUEUE_EN: evento at cycles 10, 12, 13, 14 -> pulses at cycles 11-14, 17-20, 23-26; fourth event drops with perdido=1 at cycle 15.
REQ-027 No QUEUE_EN: evento at cycles 10 and 12 -> one pulse at cycles 11-14; perdido=1 at cycle 13.
REQ-028 evento at cycle 10 and again exactly when GAP expires (cycle 16) -> second pulse at cycles 17-20, salida low exactly 2 cycles between pulses.
REQ-029 reset=0 asserted at cycle 12 during a pulse with one event pending -> salida, ocupado, and the pending count are 0 immediately; no pulse after release until a new evento.
REQ-030 evento held high for 3 cycles starting at cycle 10 with QUEUE_EN -> three pulses, perdido never high.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared state encoding and default timing for indicator-driving blocks.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    GAP    = 2'b10
  } state_t;

  localparam int PS_HOLD_CYCLES_DEFAULT = 25000000;
  localparam int PS_GAP_CYCLES_DEFAULT  = 10000000;
  localparam int PS_QUEUE_MAX_DEFAULT   = 7;

  function automatic int ps_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into HOLD_CYCLES-long pulses separated by GAP_CYCLES low cycles.
// Define PULSE_STRETCHER_QUEUE_EN to queue events arriving mid-pulse instead of dropping them.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = PS_HOLD_CYCLES_DEFAULT,
  parameter int GAP_CYCLES  = PS_GAP_CYCLES_DEFAULT,
  parameter int QUEUE_MAX   = PS_QUEUE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic evento,
  output logic salida,
  output logic ocupado,
  output logic perdido
);

  localparam int CW = $clog2(ps_max(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || QUEUE_MAX < 1) begin : g_bad_params
    $error("pulse_stretcher: HOLD_CYCLES, GAP_CYCLES and QUEUE_MAX must all be >= 1");
  end

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            salida_next, ocupado_next, perdido_next;
  logic            gap_done;
  logic            busy_event;

`ifdef PULSE_STRETCHER_QUEUE_EN
  localparam int PW = $clog2(QUEUE_MAX + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(QUEUE_MAX);
  logic [PW-1:0]   pend_reg, pend_next;
`endif

  assign gap_done   = (state_reg == GAP) && (cnt_reg == '0);
  // Events seen while a pulse or its gap is still running (not at the gap's final edge).
  assign busy_event = evento && ((state_reg == ACTIVE) || ((state_reg == GAP) && !gap_done));

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    perdido_next = 1'b0;
`ifdef PULSE_STRETCHER_QUEUE_EN
    pend_next    = pend_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (evento) begin
          state_next = ACTIVE;
          cnt_next   = HOLD_LOAD;
        end
      end
      ACTIVE: begin
        if (cnt_reg == '0) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      GAP: begin
        if (gap_done) begin
`ifdef PULSE_STRETCHER_QUEUE_EN
          if (pend_reg != '0) begin
            state_next = ACTIVE;
            cnt_next   = HOLD_LOAD;
            // A simultaneous new event takes the slot this restart frees.
            pend_next  = evento ? pend_reg : pend_reg - 1'b1;
          end else if (evento) begin
`else
          if (evento) begin
`endif
            state_next = ACTIVE;
            cnt_next   = HOLD_LOAD;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (busy_event) begin
`ifdef PULSE_STRETCHER_QUEUE_EN
      if (pend_reg == PEND_MAX) begin
        perdido_next = 1'b1;
      end else begin
        pend_next = pend_reg + 1'b1;
      end
`else
      perdido_next = 1'b1;
`endif
    end

    salida_next  = (state_next == ACTIVE);
`ifdef PULSE_STRETCHER_QUEUE_EN
    ocupado_next = (state_next != IDLE) || (pend_next != '0);
`else
    ocupado_next = (state_next != IDLE);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      salida    <= 1'b0;
      ocupado   <= 1'b0;
      perdido   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      salida    <= salida_next;
      ocupado   <= ocupado_next;
      perdido   <= perdido_next;
    end
  end

`ifdef PULSE_STRETCHER_QUEUE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Cycle-accurate bench for pulse_stretcher (HOLD=4, GAP=2, QUEUE_MAX=2); honours PULSE_STRETCHER_QUEUE_EN.
module tb_pulse_stretcher;

  logic clk;
  logic reset;
  logic evento;
  logic salida;
  logic ocupado;
  logic perdido;

  int checks   = 0;
  int failures = 0;

  // Expected {salida, ocupado, perdido} per cycle.
  logic [2:0] sb[$];

  pulse_stretcher #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2),
    .QUEUE_MAX  (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .evento (evento),
    .salida (salida),
    .ocupado(ocupado),
    .perdido(perdido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_r(input int n, input int a, input int b);
    return (n >= a) && (n <= b);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0, the first cycle after release.
  task automatic do_reset();
    evento = 1'b0;
    reset  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    sb.push_back(3'b000);
  endtask

  task automatic test_reset();
    logic [2:0] got;
    reset  = 1'b1;
    evento = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    got = {salida, ocupado, perdido};
    checks++;
    if (got !== 3'b000) begin
      failures++;
      $display("FAIL reset_async got(s,o,p)=%b required=%b", got, 3'b000);
    end
    repeat (2) @(posedge clk);
    #1;
    got = {salida, ocupado, perdido};
    checks++;
    if (got !== 3'b000) begin
      failures++;
      $display("FAIL reset_clocked got(s,o,p)=%b required=%b", got, 3'b000);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [2:0] got, e;
    int n;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      got = {salida, ocupado, perdido};
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL single cyc=%0d got(s,o,p)=%b required=%b", c, got, e);
      end
      evento = (c == 10);
      n = c + 1;
      sb.push_back({in_r(n, 11, 14), in_r(n, 11, 16), 1'b0});
      next_cycle();
    end
    evento = 1'b0;
    $display("test_single done");
  endtask

  task automatic test_queue();
    logic [2:0] got, e;
    int n;
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      got = {salida, ocupado, perdido};
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL queue cyc=%0d got(s,o,p)=%b required=%b", c, got, e);
      end
      n = c + 1;
`ifdef PULSE_STRETCHER_QUEUE_EN
      evento = (c == 10) || (c == 12) || (c == 13) || (c == 14);
      sb.push_back({in_r(n, 11, 14) || in_r(n, 17, 20) || in_r(n, 23, 26),
                    in_r(n, 11, 28), n == 15});
`else
      evento = (c == 10) || (c == 12);
      sb.push_back({in_r(n, 11, 14), in_r(n, 11, 16), n == 13});
`endif
      next_cycle();
    end
    evento = 1'b0;
    $display("test_queue done");
  endtask

  task automatic test_gap_expiry();
    logic [2:0] got, e;
    int n;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      got = {salida, ocupado, perdido};
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL gap_expiry cyc=%0d got(s,o,p)=%b required=%b", c, got, e);
      end
      evento = (c == 10) || (c == 16);
      n = c + 1;
      sb.push_back({in_r(n, 11, 14) || in_r(n, 17, 20), in_r(n, 11, 22), 1'b0});
      next_cycle();
    end
    evento = 1'b0;
    $display("test_gap_expiry done");
  endtask

  task automatic test_back_to_back();
    logic [2:0] got, e;
    int n;
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      got = {salida, ocupado, perdido};
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got(s,o,p)=%b required=%b", c, got, e);
      end
      evento = (c == 10) || (c == 12) || (c == 16);
      n = c + 1;
`ifdef PULSE_STRETCHER_QUEUE_EN
      sb.push_back({in_r(n, 11, 14) || in_r(n, 17, 20) || in_r(n, 23, 26),
                    in_r(n, 11, 28), 1'b0});
`else
      sb.push_back({in_r(n, 11, 14) || in_r(n, 17, 20), in_r(n, 11, 22), n == 13});
`endif
      next_cycle();
    end
    evento = 1'b0;
    $display("test_back_to_back done");
  endtask

  task automatic test_held();
    logic [2:0] got, e;
    int n;
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      got = {salida, ocupado, perdido};
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL held cyc=%0d got(s,o,p)=%b required=%b", c, got, e);
      end
      evento = in_r(c, 10, 12);
      n = c + 1;
`ifdef PULSE_STRETCHER_QUEUE_EN
      sb.push_back({in_r(n, 11, 14) || in_r(n, 17, 20) || in_r(n, 23, 26),
                    in_r(n, 11, 28), 1'b0});
`else
      sb.push_back({in_r(n, 11, 14), in_r(n, 11, 16), (n == 12) || (n == 13)});
`endif
      next_cycle();
    end
    evento = 1'b0;
    $display("test_held done");
  endtask

  task automatic test_reset_mid();
    logic [2:0] got, e;
    int n;
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      got = {salida, ocupado, perdido};
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_mid_pre cyc=%0d got(s,o,p)=%b required=%b", c, got, e);
      end
      evento = (c == 10) || (c == 11);
      n = c + 1;
`ifdef PULSE_STRETCHER_QUEUE_EN
      sb.push_back({n >= 11, n >= 11, 1'b0});
`else
      sb.push_back({n >= 11, n >= 11, n == 12});
`endif
      next_cycle();
    end
    evento = 1'b0;
    got = {salida, ocupado, perdido};
    e   = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL reset_mid_pre cyc=12 got(s,o,p)=%b required=%b", got, e);
    end
    reset = 1'b0;
    #1;
    got = {salida, ocupado, perdido};
    checks++;
    if (got !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_async got(s,o,p)=%b required=%b", got, 3'b000);
    end
    next_cycle();
    next_cycle();
    reset = 1'b1;
    sb.delete();
    sb.push_back(3'b000);
    for (int c = 14; c <= 32; c++) begin
      got = {salida, ocupado, perdido};
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_mid_post cyc=%0d got(s,o,p)=%b required=%b", c, got, e);
      end
      sb.push_back(3'b000);
      next_cycle();
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    reset  = 1'b1;
    evento = 1'b0;
    test_reset();
    test_single();
    test_queue();
    test_gap_expiry();
    test_back_to_back();
    test_held();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
